// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the fetched word into the IF/ID register.
// Optional halt-on-self-loop support is compiled in when FETCH_HALT_EN is defined.
module fetch_stage #(
  parameter int                   PC_W       = 16,
  parameter int                   INSTR_W    = 16,
  parameter logic [PC_W-1:0]      RESET_PC   = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR  = '0,
  parameter logic [INSTR_W-1:0]   HALT_INSTR = 16'hC03F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               if_id_valid,
  output logic               halted
);

  logic [PC_W-1:0]    pc, pc_next, pc_inc;
  logic [INSTR_W-1:0] instr_next;
  logic [PC_W-1:0]    pc1_next;
  logic               valid_next;
  logic               is_halted;
  logic               halt_hit;

  // Natural wrap at 2^PC_W: the adder simply drops the carry.
  assign pc_inc = pc + PC_W'(1);
  assign pc_out = pc;

`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_next;

  assign is_halted = (state == HALT);
  assign halt_hit  = (instr_in == HALT_INSTR);
  assign halted    = is_halted;
`else
  logic unused_halt_cfg;

  assign is_halted       = 1'b0;
  assign halt_hit        = 1'b0;
  assign halted          = 1'b0;
  assign unused_halt_cfg = ^HALT_INSTR;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    pc_next    = pc;
    instr_next = if_id_instr;
    pc1_next   = if_id_pc1;
    valid_next = if_id_valid;
`ifdef FETCH_HALT_EN
    state_next = state;
`endif
    if (is_halted) begin
      // Frozen PC; a bubble goes to decode every cycle until reset.
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end else if (branch_taken) begin
      pc_next    = branch_target;
      instr_next = NOP_INSTR;
      pc1_next   = '0;
      valid_next = 1'b0;
    end else if (!stall) begin
      instr_next = instr_in;
      pc1_next   = pc_inc;
      valid_next = 1'b1;
      if (halt_hit) begin
`ifdef FETCH_HALT_EN
        state_next = HALT;
`endif
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
`ifdef FETCH_HALT_EN
      state       <= RUN;
`endif
    end else begin
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc1   <= pc1_next;
      if_id_valid <= valid_next;
`ifdef FETCH_HALT_EN
      state       <= state_next;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, halt/self-loop sequence,
// and randomized traffic checked against a rule-level reference model.
module tb_fetch_stage;

  localparam logic [15:0] HALT_WORD = 16'hC03F;
  localparam logic [15:0] HALT_ADDR = 16'd39;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target, instr_in;
  logic [15:0] pc_out, if_id_instr, if_id_pc1;
  logic        if_id_valid, halted;
  logic        mem_mode;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc_out(pc_out),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: identity or scrambled contents, halt word always at 39.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic mode);
    logic [15:0] h;
    if (a == HALT_ADDR) return HALT_WORD;
    h = a * 16'h9E37;
    return mode ? (h ^ 16'h5A5A) : a;
  endfunction

  always_comb instr_in = mem_word(pc_out, mem_mode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e_pc, input logic [15:0] e_ins,
                            input logic [15:0] e_pc1, input logic e_v, input logic e_h,
                            input logic chk_pc1);
    check({tag, ".pc"},     32'(pc_out),      32'(e_pc));
    check({tag, ".instr"},  32'(if_id_instr), 32'(e_ins));
    if (chk_pc1) check({tag, ".pc1"}, 32'(if_id_pc1), 32'(e_pc1));
    check({tag, ".valid"},  32'(if_id_valid), 32'(e_v));
    check({tag, ".halted"}, 32'(halted),      32'(e_h));
  endtask

  // Apply inputs for one edge; caller compares afterwards (#1 past the edge).
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, s, b;
    logic [15:0] t;
    logic [15:0] e_pc, e_ins, e_pc1;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic b, input logic [15:0] t,
                              input logic [15:0] pc, input logic [15:0] ins,
                              input logic [15:0] pc1, input logic v);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.t = t;
    x.e_pc = pc; x.e_ins = ins; x.e_pc1 = pc1; x.e_v = v;
    vecs.push_back(x);
  endfunction

  // Reference model state, updated by the rules of one clock edge.
  logic [15:0] m_pc, m_ins, m_pc1;
  logic        m_v, m_h;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  function automatic void model_edge(input logic r, input logic s, input logic b,
                                     input logic [15:0] t);
    logic [15:0] w;
    if (r) begin
      m_pc = 16'h0; m_ins = 16'h0; m_pc1 = 16'h0; m_v = 1'b0; m_h = 1'b0;
    end else if (m_h) begin
      m_ins = 16'h0; m_v = 1'b0;
    end else if (b) begin
      m_pc = t; m_ins = 16'h0; m_pc1 = 16'h0; m_v = 1'b0;
    end else if (!s) begin
      w     = mem_word(m_pc, mem_mode);
      m_ins = w;
      m_pc1 = 16'((int'(m_pc) + 1) % 65536);
      m_v   = 1'b1;
      if (HALT_EN && w == HALT_WORD) m_h = 1'b1;
      else m_pc = m_pc1;
    end
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0; mem_mode = 1'b0;
    #1;

    // reset, streaming, stall, branch+stall, wrap, self-target, reset vs branch
    add(1,0,0,16'h0,    16'h0,    16'h0,    16'h0, 0);
    add(0,0,0,16'h0,    16'h1,    16'h0,    16'h1, 1);
    add(0,0,0,16'h0,    16'h2,    16'h1,    16'h2, 1);
    add(0,0,0,16'h0,    16'h3,    16'h2,    16'h3, 1);
    add(0,0,0,16'h0,    16'h4,    16'h3,    16'h4, 1);
    add(0,0,0,16'h0,    16'h5,    16'h4,    16'h5, 1);
    for (int i = 0; i < 3; i++) add(0,1,0,16'h0, 16'h5, 16'h4, 16'h5, 1);
    add(0,0,0,16'h0,    16'h6,    16'h5,    16'h6, 1);
    add(0,0,0,16'h0,    16'h7,    16'h6,    16'h7, 1);
    for (int i = 8; i <= 10; i++)
      add(0,0,0,16'h0, 16'(i), 16'(i-1), 16'(i), 1);
    add(0,1,1,16'd32,   16'd32,   16'h0,    16'h0,  0);
    add(0,0,0,16'h0,    16'd33,   16'd32,   16'd33, 1);
    add(0,0,1,16'hFFFF, 16'hFFFF, 16'h0,    16'h0,  0);
    add(0,0,0,16'h0,    16'h0,    16'hFFFF, 16'h0,  1);
    add(0,0,0,16'h0,    16'h1,    16'h0,    16'h1,  1);
    add(0,0,1,16'h1,    16'h1,    16'h0,    16'h0,  0);
    add(0,0,1,16'h1,    16'h1,    16'h0,    16'h0,  0);
    add(0,0,0,16'h0,    16'h2,    16'h1,    16'h2,  1);
    add(0,0,0,16'h0,    16'h3,    16'h2,    16'h3,  1);
    add(1,0,1,16'd50,   16'h0,    16'h0,    16'h0,  0);
    add(0,0,0,16'h0,    16'h1,    16'h0,    16'h1,  1);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].t);
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_pc1,
                 vecs[i].e_v, 1'b0, 1'b1);
    end

    // Halt word at address 39.
    step(0,0,1,16'd38); check_outs("h_br38", 16'd38, 16'h0,  16'h0,  0, 0, 1);
    step(0,0,0,16'h0);  check_outs("h_f38",  16'd39, 16'd38, 16'd39, 1, 0, 1);
`ifdef FETCH_HALT_EN
    step(0,1,0,16'h0);  check_outs("h_stall", 16'd39, 16'd38,    16'd39, 1, 0, 1);
    step(0,0,0,16'h0);  check_outs("h_hit",   16'd39, HALT_WORD, 16'd40, 1, 1, 1);
    step(0,0,1,16'd5);  check_outs("h_brign", 16'd39, 16'h0,     16'h0,  0, 1, 0);
    step(0,1,0,16'h0);  check_outs("h_stign", 16'd39, 16'h0,     16'h0,  0, 1, 0);
    step(1,0,0,16'h0);  check_outs("h_rst",   16'h0,  16'h0,     16'h0,  0, 0, 1);
    step(0,0,0,16'h0);  check_outs("h_run",   16'h1,  16'h0,     16'h1,  1, 0, 1);
`else
    step(0,0,0,16'h0);  check_outs("h_f39",   16'd40, HALT_WORD, 16'd40, 1, 0, 1);
    step(0,0,1,16'd39); check_outs("h_loop",  16'd39, 16'h0,     16'h0,  0, 0, 1);
    step(0,0,0,16'h0);  check_outs("h_f39b",  16'd40, HALT_WORD, 16'd40, 1, 0, 1);
`endif

    // Randomized traffic against the reference model.
    mem_mode = 1'b1;
    m_pc = 16'h0; m_ins = 16'h0; m_pc1 = 16'h0; m_v = 1'b0; m_h = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic        r, s, b, was_h;
      logic [15:0] t;
      r = (n == 0) || ($urandom_range(0, 23) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       t = 16'hFFFF - 16'($urandom_range(0, 2));
        1:       t = HALT_ADDR - 16'($urandom_range(0, 2));
        default: t = 16'($urandom);
      endcase
      was_h = m_h;
      model_edge(r, s, b, t);
      step(r, s, b, t);
      check_outs($sformatf("rnd%0d", n), m_pc, m_ins, m_pc1, m_v, m_h, !(was_h && !r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
